// File: rtl/sga_pkg.sv
// sga_pkg: shared types and constants for the snake game controller
package sga_pkg;
  typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  localparam logic [3:0] POS_INIT   = 4'd5;
  localparam logic [3:0] APPLE_INIT = 4'd10;
  localparam logic [3:0] LFSR_SEED  = 4'b1001;
  localparam int         GRID_DIM   = 4;
endpackage

// File: rtl/sga_lfsr4.sv
// sga_lfsr4: free-running 4-bit Fibonacci LFSR, x^4+x^3+1, period 15
module sga_lfsr4
  import sga_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] value
);
  // shift left, feeding back the xor of the two top taps
  always_ff @(posedge clock)
    value <= reset ? LFSR_SEED : {value[2:0], value[3] ^ value[2]};
endmodule

// File: rtl/snake_step_ctrl.sv
// snake_step_ctrl: single-cell snake game state on a 4x4 grid, stepped by a tick counter
module snake_step_ctrl
  import sga_pkg::*;
#(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int CNT_W       = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [3:0] position,
  output logic [3:0] apple,
  output logic [3:0] score,
  output logic       ate,
  output logic       playing,
  output logic       game_over
);
  state_t           state, state_n;
  dir_t             dir, dir_eff;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lfsr, head_n;
  logic [1:0]       row, col;
  logic             in_play, tick, wall, restart, eat;

  sga_lfsr4 u_lfsr (.clock(clock), .reset(reset), .value(lfsr));

  assign row = position[3:2];
  assign col = position[1:0];

  // direction choice, step tick, next head, wall/eat detection and next FSM state
  always_comb begin
    in_play = state == PLAY;
    dir_eff = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : btn_right ? RIGHT : dir;
    tick    = in_play && cnt == CNT_W'(STEP_CYCLES - 1);
    wall    = (dir_eff == UP    && row == 2'd0) ||
              (dir_eff == DOWN  && row == 2'(GRID_DIM - 1)) ||
              (dir_eff == LEFT  && col == 2'd0) ||
              (dir_eff == RIGHT && col == 2'(GRID_DIM - 1));
    head_n  = dir_eff == UP   ? {row - 2'd1, col} :
              dir_eff == DOWN ? {row + 2'd1, col} :
              dir_eff == LEFT ? {row, col - 2'd1} : {row, col + 2'd1};
    restart = !in_play && start;
    eat     = tick && !wall && head_n == apple;
    state_n = (tick && wall) ? OVER : restart ? PLAY : state;
  end

  // state register with status flags decoded from the next state so they stay registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      playing   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      playing   <= state_n == PLAY;
      game_over <= state_n == OVER;
    end
  end

  // game datapath: counter, direction, head, apple relocation and score
  always_ff @(posedge clock) begin
    if (reset) begin
      position <= POS_INIT;
      apple    <= APPLE_INIT;
      score    <= 4'd0;
      ate      <= 1'b0;
      dir      <= RIGHT;
      cnt      <= '0;
    end else begin
      ate <= eat;
      if (restart) begin
        position <= POS_INIT;
        apple    <= APPLE_INIT;
        score    <= 4'd0;
        dir      <= RIGHT;
        cnt      <= '0;
      end else if (in_play) begin
        dir <= dir_eff;
        cnt <= tick ? '0 : cnt + CNT_W'(1);
        if (tick && !wall) position <= head_n;
        if (eat) begin
          score <= score == 4'd15 ? score : score + 4'd1;
          apple <= lfsr == head_n ? lfsr + 4'd1 : lfsr;
        end
      end
    end
  end
endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb_snake_step_ctrl: directed game scenarios checked against a row/col game model
module tb_snake_step_ctrl;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [3:0] position, apple, score;
  logic ate, playing, game_over;

  int tests = 0, errs = 0;
  bit armed = 0;
  int seq [15];
  int m_st, m_r, m_c, m_apple, m_score, m_dir, m_cnt, m_k, eats = 0;
  bit m_ate;

  snake_step_ctrl #(.STEP_CYCLES(4), .CNT_W(2)) dut (
    .clock(clock), .reset(reset), .start(start),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .position(position), .apple(apple), .score(score),
    .ate(ate), .playing(playing), .game_over(game_over)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // game model: state 0 idle / 1 play / 2 over, dir 0 up / 1 down / 2 left / 3 right
  always @(posedge clock) begin
    int nr, nc, h;
    if (reset) begin
      m_st = 0; m_r = 1; m_c = 1; m_apple = 10; m_score = 0;
      m_ate = 0; m_dir = 3; m_cnt = 0; m_k = 0;
    end else begin
      m_ate = 0;
      if (m_st == 1) begin
        if (btn_up) m_dir = 0;
        else if (btn_down) m_dir = 1;
        else if (btn_left) m_dir = 2;
        else if (btn_right) m_dir = 3;
        if (m_cnt == 3) begin
          m_cnt = 0;
          nr = m_r + (m_dir == 1 ? 1 : 0) - (m_dir == 0 ? 1 : 0);
          nc = m_c + (m_dir == 3 ? 1 : 0) - (m_dir == 2 ? 1 : 0);
          if (nr < 0 || nr > 3 || nc < 0 || nc > 3) m_st = 2;
          else begin
            m_r = nr; m_c = nc; h = nr * 4 + nc;
            if (h == m_apple) begin
              m_score = m_score < 15 ? m_score + 1 : 15;
              m_ate = 1;
              eats++;
              m_apple = seq[m_k] == h ? (seq[m_k] + 1) % 16 : seq[m_k];
            end
          end
        end else m_cnt++;
      end else if (start) begin
        m_st = 1; m_cnt = 0; m_r = 1; m_c = 1; m_apple = 10; m_score = 0; m_dir = 3;
      end
      m_k = (m_k + 1) % 15;
    end
  end

  always @(negedge clock) if (armed) begin
    check("position", position, m_r * 4 + m_c);
    check("apple", apple, m_apple);
    check("score", score, m_score);
    check("ate", ate, m_ate);
    check("playing", playing, m_st == 1);
    check("game_over", game_over, m_st == 2);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(1); start = 1'b0;
  endtask

  initial begin
    seq[0] = 9;
    for (int i = 1; i < 15; i++)
      seq[i] = ((seq[i-1] << 1) & 15) | (((seq[i-1] >> 3) ^ (seq[i-1] >> 2)) & 1);
    check("lfsr_seq1", seq[1], 3);
    check("lfsr_seq4", seq[4], 10);
    check("lfsr_seq14", seq[14], 4);
    cyc(2);
    armed = 1;
    check("rst_pos", position, 5);
    check("rst_apple", apple, 10);
    check("rst_score", score, 0);
    check("rst_playing", playing, 0);
    reset = 1'b0;
    cyc(1);
    pulse_start();
    check("start_playing", playing, 1);
    cyc(4);
    check("walk_pos6", position, 6);
    cyc(4);
    check("walk_pos7", position, 7);
    btn_right = 1'b1;
    cyc(4);
    btn_right = 1'b0;
    check("wall_pos", position, 7);
    check("wall_over", game_over, 1);
    check("wall_playing", playing, 0);
    check("wall_score", score, 0);
    cyc(3);
    check("over_frozen", position, 7);
    pulse_start();
    check("restart_pos", position, 5);
    check("restart_apple", apple, 10);
    cyc(4);
    check("restart_pos6", position, 6);
    btn_down = 1'b1; cyc(1); btn_down = 1'b0;
    cyc(3);
    check("eat_pos", position, 10);
    check("eat_ate", ate, 1);
    check("eat_score", score, 1);
    cyc(1);
    check("eat_ate_clear", ate, 0);
    reset = 1'b1; cyc(1); reset = 1'b0;
    pulse_start();
    btn_up = 1'b1; btn_left = 1'b1;
    cyc(4);
    btn_up = 1'b0; btn_left = 1'b0;
    check("prio_up_pos", position, 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    pulse_start();
    cyc(3);
    reset = 1'b1; btn_down = 1'b1;
    cyc(1);
    reset = 1'b0; btn_down = 1'b0;
    check("midrst_pos", position, 5);
    check("midrst_apple", apple, 10);
    check("midrst_score", score, 0);
    check("midrst_playing", playing, 0);
    cyc(2);
    check("midrst_idle_pos", position, 5);
    pulse_start();
    cyc(4);
    check("resume_pos6", position, 6);
    eats = 0;
    for (int i = 0; i < 3000 && eats < 16; i++) begin
      btn_up    = (m_apple / 4) < m_r;
      btn_down  = (m_apple / 4) > m_r;
      btn_left  = (m_apple / 4) == m_r && (m_apple % 4) < m_c;
      btn_right = (m_apple / 4) == m_r && (m_apple % 4) > m_c;
      cyc(1);
    end
    check("eat16_reached", eats >= 16, 1);
    check("sat_score", score, 15);
    check("sat_ate", ate, 1);
    btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
- Upstream stage of the LED-matrix renderer in the snake game (SGA).
- Owns game state: head position, apple position, direction and score on the 4x4 playfield.
- Advances the head one cell per step tick, detects wall hits and apple eating, and relocates the apple pseudo-randomly.
- Drives the renderer's 4-bit position and apple inputs directly.

Parameters:
- STEP_CYCLES, 25_000_000, clock cycles per movement step; minimum 2.
- CNT_W, 25, width of the step counter; must satisfy 2^CNT_W >= STEP_CYCLES.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins or restarts a game.
- btn_up  input  1  level, already debounced.
- btn_down  input  1  level, already debounced.
- btn_left  input  1  level, already debounced.
- btn_right  input  1  level, already debounced.
- position  output  4  head cell; index = row*4 + col; row = [3:2], col = [1:0].
- apple  output  4  apple cell, same encoding.
- score  output  4  apples eaten; saturates at 15.
- ate  output  1  one-cycle pulse when an apple is eaten.
- playing  output  1  high in PLAY.
- game_over  output  1  high in OVER.

Behaviour:
- All outputs are registered. Reset state:
  - position=5, apple=10, score=0, ate=0, playing=0, game_over=0.
  - dir=RIGHT, FSM=IDLE, step counter=0, LFSR=4'b1001.
- FSM states:
  - IDLE: waits for start.
  - PLAY: step counter runs; buttons are sampled.
  - OVER: outputs frozen.
- Transitions:
  - IDLE -> PLAY on start; counter cleared.
  - PLAY -> OVER on a wall hit.
  - OVER -> PLAY on start; position, apple, score and dir are reloaded with their reset values and the counter is cleared. The LFSR is not reloaded.
  - start in PLAY is ignored.
- Direction:
  - Sampled every PLAY cycle. Priority: up > down > left > right.
  - No button pressed: dir is held.
  - Reversal is allowed (single-cell snake).
- Step tick:
  - Counter counts 0..STEP_CYCLES-1 in PLAY and wraps to 0.
  - Tick = (counter == STEP_CYCLES-1) while in PLAY.
  - The counter holds its value in IDLE and OVER.
- On a tick, the next head is computed from the current dir. A button sampled in the tick cycle takes effect on that same tick.
  - up: row-1; down: row+1; left: col-1; right: col+1.
- Wall hit (row or col would leave 0..3):
  - position is held; the FSM enters OVER at that edge; game_over=1 and playing=0 from the next cycle.
  - Apple and score are unchanged.
- Otherwise, position takes the next head at the tick edge.
- Eating: if the next head == apple, then at the same edge:
  - score increments, saturating at 15;
  - ate=1 for exactly one cycle;
  - apple <= LFSR value. If that value equals the new head, apple <= (value+1) mod 16.
- LFSR:
  - 4-bit Fibonacci, taps x^4+x^3+1; advances every clock cycle in every state except reset.
  - Never reaches 0; sequence length 15.
- Latency:
  - position, apple and score update at the edge ending the tick cycle.
  - The renderer sees new values one cycle after the tick.
- Reset mid-game: at the next edge, everything returns to reset values regardless of tick or button inputs.
- Simultaneous events:
  - reset dominates all others.
  - A wall hit dominates eating (cannot coincide, since the apple is always in-grid).
  - A start pulse on the same cycle as a tick in PLAY is ignored.

Decomposition:
- Shared package (sga_pkg): direction enum (UP, DOWN, LEFT, RIGHT), FSM state enum, constants POS_INIT=5, APPLE_INIT=10, LFSR_SEED=4'b1001, GRID_DIM=4.
- One natural sub-module: sga_lfsr4 (clock, reset, 4-bit value, free-running).

Test Plan (STEP_CYCLES=4):
- Reset, then start, no buttons -> position goes 5 -> 6 -> 7 on successive ticks, 4 cycles apart; playing=1.
- Hold right from position 7, tick -> position stays 7; game_over=1 and playing=0 the next cycle; score stays 0.
- Press down for one cycle from position 6 (apple at 10), tick -> position=10, ate=1 for one cycle, score=1, apple = current LFSR value (or +1 if that equals 10).
- Press up and left in the same cycle from position 5 -> position=1 (up wins).
- Force score to 15 and eat an apple -> score stays 15 and ate still pulses.
- Assert reset mid-PLAY, on a tick cycle with a button held -> position=5, apple=10, score=0, FSM in IDLE; start again -> play resumes normally.
